dsc_mul_sched: RTL and testbench

Scheduler that shares one serial deterministic-stochastic multiplier (dsc_mul, ports clk/rst/en/a/b/z/ov) between NUM_REQ requesters. It arbitrates multiply requests round-robin and sequences the multiplier: clear, enable, wait for ov, then capture z. It returns the product with the requester id, a run-cycle count and an error flag. It sits between requester logic and a single dsc_mul instance and replaces per-test manual rst/en sequencing.

---
 rtl/dsc_mul_sched.sv | 202 ++++++++++++++++++++
 tb/tb_dsc_mul_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin scheduler sharing one serial dsc_mul unit.
// Optional feature macro: ZERO_BYPASS_EN (zero operands skip the multiplier).
module dsc_mul_sched #(
    parameter int NUM_BITS = 10,
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 1,
    parameter int CYC_W    = 24,
    parameter int MAX_CYC  = 1048592
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_a,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [2*NUM_BITS-1:0]       rsp_z,
    output logic [CYC_W-1:0]            rsp_cycles,
    output logic                        rsp_err,
    output logic                        mul_rst,
    output logic                        mul_en,
    output logic [NUM_BITS-1:0]         mul_a,
    output logic [NUM_BITS-1:0]         mul_b,
    input  logic [2*NUM_BITS-1:0]       mul_z,
    input  logic                        mul_ov
);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     lo_id;
    logic [ID_W-1:0]     hi_id;
    logic [ID_W-1:0]     nxt_ptr;
    logic                lo_hit;
    logic                hi_hit;
    logic                win_vld;
    logic                grant;
    logic                zero_op;
    logic                run_ov;
    logic                run_to;
    logic [NUM_BITS-1:0] sel_a;
    logic [NUM_BITS-1:0] sel_b;
    logic [CYC_W-1:0]    cnt;
    logic [CYC_W-1:0]    cnt_inc;

    // Winner: lowest valid index at/above rr_ptr, else lowest valid overall
    always_comb begin
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_id  = '0;
        hi_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_hit = 1'b1;
                lo_id  = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_hit = 1'b1;
                    hi_id  = ID_W'(i);
                end
            end
        end
        win_vld = lo_hit;
        win_id  = hi_hit ? hi_id : lo_id;
    end

    // Operand slices of the current winner
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                sel_a = req_a[i*NUM_BITS +: NUM_BITS];
                sel_b = req_b[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    // Ready is gated by reset so nothing looks accepted while held in reset
    assign grant   = (state == IDLE) && win_vld && rst;
    assign nxt_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    // One-hot accept toward the winning requester
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
    end

`ifdef ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign cnt_inc = cnt + 1'b1;
    assign run_ov  = (state == RUN) && mul_ov;
    assign run_to  = (state == RUN) && !mul_ov &&
                     (cnt_inc == CYC_W'(MAX_CYC));

    // Next state and the multiplier/response strobes decoded from state
    always_comb begin
        state_nx  = state;
        mul_rst   = 1'b1;
        mul_en    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = zero_op ? DONE : CLR;
                end
            end
            CLR: begin
                state_nx = RUN;
            end
            RUN: begin
                mul_rst = 1'b0;
                mul_en  = 1'b1;
                if (run_ov || run_to) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant-time capture: pointer, id and operands held through the run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            rsp_id <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else if (grant) begin
            rr_ptr <= nxt_ptr;
            rsp_id <= win_id;
            mul_a  <= sel_a;
            mul_b  <= sel_b;
        end
    end

    // Run-cycle counter: cleared in CLR, counts every RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == CLR) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt_inc;
        end
    end

    // Response capture; ov on the timeout cycle counts as completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_z      <= '0;
            rsp_cycles <= '0;
            rsp_err    <= 1'b0;
        end else if (grant && zero_op) begin
            rsp_z      <= '0;
            rsp_cycles <= '0;
            rsp_err    <= 1'b0;
        end else if (run_ov) begin
            rsp_z      <= mul_z;
            rsp_cycles <= cnt_inc;
            rsp_err    <= 1'b0;
        end else if (run_to) begin
            rsp_z      <= '0;
            rsp_cycles <= CYC_W'(MAX_CYC);
            rsp_err    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// tb_dsc_mul_sched: table vectors, reset sequence and random traffic
// against a transaction-level model; dsc_mul replaced by a latency stub.
module tb_dsc_mul_sched;

    localparam int MC = 8;

`ifdef ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [19:0] req_a = '0;
    logic [19:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [0:0]  rsp_id;
    logic [19:0] rsp_z;
    logic [23:0] rsp_cycles;
    logic        rsp_err;
    logic        mul_rst;
    logic        mul_en;
    logic [9:0]  mul_a;
    logic [9:0]  mul_b;
    logic [19:0] mul_z;
    logic        mul_ov;

    int   total = 0;
    int   bad   = 0;
    int   mrr   = 0;
    int   stub_lat = 0;
    logic stub_junk = 1'b0;
    int   run_cnt = 0;

    dsc_mul_sched #(
        .NUM_BITS(10), .NUM_REQ(2), .ID_W(1), .CYC_W(24), .MAX_CYC(MC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z),
        .rsp_cycles(rsp_cycles), .rsp_err(rsp_err),
        .mul_rst(mul_rst), .mul_en(mul_en),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_z(mul_z), .mul_ov(mul_ov)
    );

    always #5 clk = ~clk;

    // Stub multiplier: ov on the stub_lat-th enabled cycle (0 = never)
    always @(posedge clk) begin
        if (mul_rst) run_cnt <= 0;
        else if (mul_en) run_cnt <= run_cnt + 1;
    end
    assign mul_ov = mul_en ? (stub_lat != 0 && run_cnt == stub_lat - 1)
                           : stub_junk;
    assign mul_z  = mul_en ? ({10'b0, mul_a} * {10'b0, mul_b}) : 20'hABCDE;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [9:0]  a0, b0, a1, b1;
        int          lat;
        logic        junk;
        int          bp;
        int          eid;
        logic [19:0] ez;
        int          ecyc;
        logic        eerr;
    } vec_t;

    task automatic txn(input vec_t t);
        int n, en_n, busy_bad, st_bad, exp_lat;
        logic [9:0]  ea, eb;
        logic [0:0]  hid;
        logic [19:0] hz;
        logic [23:0] hc;
        logic        he;
        req_valid = t.v;
        req_a = {t.a1, t.a0};
        req_b = {t.b1, t.b0};
        stub_lat = t.lat;
        stub_junk = t.junk;
        rsp_ready = 1'b0;
        ea = (t.eid == 1) ? t.a1 : t.a0;
        eb = (t.eid == 1) ? t.b1 : t.b0;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("grant_seen", req_ready != 2'b00, 1);
        chk("grant_who", req_ready, 2'b01 << t.eid);
        @(posedge clk); #1;
        n = 0; en_n = 0; busy_bad = 0;
        while (!rsp_valid && n < 40) begin
            if (mul_en) en_n++;
            if (req_ready != 2'b00) busy_bad++;
            if (mul_en == mul_rst) busy_bad++;
            if (mul_a != ea || mul_b != eb) busy_bad++;
            @(posedge clk); #1; n++;
        end
        exp_lat = (t.ecyc == 0) ? 0 : 1 + t.ecyc;
        chk("rsp_latency", n, exp_lat);
        chk("busy_clean", busy_bad, 0);
        chk("en_cycles", en_n, t.ecyc);
        chk("rsp_id", rsp_id, t.eid);
        chk("rsp_z", rsp_z, t.ez);
        chk("rsp_cycles", rsp_cycles, t.ecyc);
        chk("rsp_err", rsp_err, t.eerr);
        chk("done_mul_idle", {mul_rst, mul_en}, 2'b10);
        hid = rsp_id; hz = rsp_z; hc = rsp_cycles; he = rsp_err;
        st_bad = 0;
        for (int i = 0; i < t.bp; i++) begin
            stub_junk = 1'($urandom);
            @(posedge clk); #1;
            if (!rsp_valid || rsp_id != hid || rsp_z != hz ||
                rsp_cycles != hc || rsp_err != he || req_ready != 2'b00)
                st_bad++;
        end
        chk("bp_stable", st_bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        chk("regrant_ready", req_ready != 2'b00, t.v != 2'b00);
        mrr = (t.eid + 1) % 2;
    endtask

    vec_t tbl[9];

    initial begin
        vec_t r;
        int   n;
        logic [9:0] ea, eb;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        int   n;
        logic [9:0] ea, eb;

        tbl[0] = '{2'b11, 10'd1023, 10'd1023, 10'd1023, 10'd1023,
                   3, 1'b0, 0, 0, 20'd1046529, 3, 1'b0};
        tbl[1] = '{2'b11, 10'd1023, 10'd1023, 10'd1023, 10'd1023,
                   5, 1'b1, 0, 1, 20'd1046529, 5, 1'b0};
        tbl[2] = '{2'b11, 10'd1023, 10'd1023, 10'd1023, 10'd1023,
                   2, 1'b0, 1, 0, 20'd1046529, 2, 1'b0};
        tbl[3] = '{2'b01, 10'd3, 10'd5, 10'd0, 10'd0,
                   4, 1'b0, 0, 0, 20'd15, 4, 1'b0};
        tbl[4] = '{2'b10, 10'd0, 10'd0, 10'd200, 10'd300,
                   6, 1'b1, 10, 1, 20'd60000, 6, 1'b0};
        tbl[5] = '{2'b01, 10'd7, 10'd9, 10'd0, 10'd0,
                   0, 1'b0, 0, 0, 20'd0, MC, 1'b1};
        tbl[6] = '{2'b10, 10'd0, 10'd0, 10'd12, 10'd11,
                   8, 1'b1, 1, 1, 20'd132, 8, 1'b0};
        tbl[7] = '{2'b01, 10'd1023, 10'd1, 10'd0, 10'd0,
                   1, 1'b0, 0, 0, 20'd1023, 1, 1'b0};
        tbl[8] = '{2'b10, 10'd5, 10'd5, 10'd0, 10'd700,
                   3, 1'b1, 0, 1, 20'd0, BYP ? 0 : 3, 1'b0};

        // reset state, with requests already pending
        req_valid = 2'b11;
        req_a = {10'd9, 10'd9};
        req_b = {10'd9, 10'd9};
        stub_junk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b000);
        chk("rst_z", rsp_z, 0);
        chk("rst_cycles", rsp_cycles, 0);
        chk("rst_mul", {mul_rst, mul_en}, 2'b10);
        chk("rst_ops", {mul_a, mul_b}, 0);
        req_valid = 2'b00;
        stub_junk = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) txn(tbl[i]);
        req_valid = 2'b00;

        // reset in the 4th RUN cycle, after a grant moved rr_ptr to 1
        req_valid = 2'b01;
        req_a = {10'd0, 10'd5};
        req_b = {10'd0, 10'd6};
        stub_lat = 0;
        #1;
        chk("rr_grant0", req_ready, 2'b01);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("run4_en", mul_en, 1);
        rst = 1'b0;
        #1;
        chk("rst_run_mul", {mul_rst, mul_en}, 2'b10);
        chk("rst_run_valid", rsp_valid, 0);
        chk("rst_run_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid || mul_en) n++;
        end
        chk("no_stale_rsp", n, 0);
        mrr = 0;
        r = '{2'b11, 10'd21, 10'd2, 10'd33, 10'd3,
              2, 1'b0, 0, 0, 20'd42, 2, 1'b0};
        txn(r);

        // random traffic against the transaction model
        for (int t = 0; t < 40; t++) begin
            r.v = 2'($urandom_range(1, 3));
            r.a0 = 10'($urandom);
            r.b0 = 10'($urandom);
            r.a1 = 10'($urandom);
            r.b1 = 10'($urandom);
            if ($urandom_range(0, 5) == 0) r.a0 = '0;
            if ($urandom_range(0, 5) == 0) r.b1 = '0;
            r.lat = $urandom_range(0, 9);
            r.junk = 1'($urandom);
            r.bp = $urandom_range(0, 3);
            r.eid = -1;
            for (int k = 0; k < 2; k++) begin
                int i;
                i = (mrr + k) % 2;
                if (r.v[i] && r.eid < 0) r.eid = i;
            end
            ea = (r.eid == 1) ? r.a1 : r.a0;
            eb = (r.eid == 1) ? r.b1 : r.b0;
            if (BYP && (ea == 0 || eb == 0)) begin
                r.ez = 0; r.ecyc = 0; r.eerr = 1'b0;
            end else if (r.lat >= 1 && r.lat <= MC) begin
                r.ez = ea * eb; r.ecyc = r.lat; r.eerr = 1'b0;
            end else begin
                r.ez = 0; r.ecyc = MC; r.eerr = 1'b1;
            end
            txn(r);
        end
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
